credit_based_transmitter: RTL and testbench
===========================================

# credit_based_transmitter

Sending end of the credit-based flow-control link: accepts words from a local valid/ready producer and forwards them over a credit-based channel to a remote credit-based FIFO, one word per available credit. It tracks the receiver's free slots with an internal credit counter, preset to the receiver depth at reset and replenished by returned credit pulses. Output is registered, so the block sits directly at a clock-domain-local link boundary.

## Interface

- WIDTH, default 8: data word width in bits.
- CREDIT_COUNT, default 4: initial and maximum credits; must equal the remote receiver's buffer depth. Must be ≥ 1.
- CREDIT_WIDTH (localparam): clog2(CREDIT_COUNT+1). 3 bits for CREDIT_COUNT=4.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- write_data  in  WIDTH  word from local producer.
- write_valid  in  1  producer offers write_data.
- write_ready  out  1  block can accept a word this cycle.
- transmit_data  out  WIDTH  registered word to the link.
- transmit_valid  out  1  single-cycle pulse per word sent.
- transmit_credit  in  1  single-cycle pulse; one returned credit per high cycle.
- credits_available  out  CREDIT_WIDTH  current credit counter value.
- credit_overflow  out  1  sticky error: credit returned while counter already at CREDIT_COUNT.
- idle  out  1  all credits home and nothing in flight from this block.

## Operation

- Reset (async assert, sync release): credits_available=CREDIT_COUNT, transmit_valid=0, transmit_data=0, credit_overflow=0, write_ready=1, idle=1.
- write_ready = (credits_available != 0); combinational from the counter register only, never from transmit_credit or write_valid.
- Transfer: cycle with write_valid & write_ready. Any word not transferred is not captured.
- On transfer: transmit_data <= write_data, transmit_valid <= 1 next cycle. With no transfer, transmit_valid <= 0 and transmit_data holds its last value.
- Counter update per cycle, consume = transfer, ret = transmit_credit:
  - consume only: count − 1.
  - ret only, count < CREDIT_COUNT: count + 1.
  - ret only, count == CREDIT_COUNT: count unchanged (saturate), credit_overflow <= 1.
  - consume & ret: unchanged, no overflow even at CREDIT_COUNT.
  - neither: unchanged.
- Counter never underflows: consume impossible at 0 because write_ready=0.
- credit_overflow stays 1 until reset; it has no effect on data flow.
- idle = (credits_available == CREDIT_COUNT) & ~transmit_valid.
- Reset mid-operation: in-flight transmit_valid dropped immediately, counter restored to CREDIT_COUNT. Remote receiver must be reset in the same window; no recovery of lost credits otherwise.

## Timing

- Latency write to link: 1 cycle (transfer at cycle N → transmit_valid high at N+1).
- Throughput: one word per cycle while credits_available > 0; back-to-back transmit_valid pulses allowed.
- Credit returned at cycle N is usable at N+1: write_ready rises at N+1 if the counter was 0.
- Full burst from reset: exactly CREDIT_COUNT consecutive transfers before write_ready falls.
- credits_available and idle reflect registered state, updated on the clock edge after the event.

## Test plan

- Reset: assert reset with arbitrary inputs → transmit_valid=0, transmit_data=0, credits_available=4, write_ready=1, credit_overflow=0, idle=1.
- Burst, no credits returned: write_valid=1, data 0x11,0x22,0x33,0x44,0x55 from cycle 0 → transfers at cycles 0–3, transmit_valid at 1–4 with 0x11–0x44, write_ready=0 from cycle 4, credits_available=0, 0x55 held off.
- Credit refill: at credits 0 pulse transmit_credit at cycle 6 → write_ready=1 at cycle 7, 0x55 transferred, transmit_valid with 0x55 at cycle 8, credits back to 0.
- Simultaneous: credits=2, transfer plus transmit_credit same cycle → credits stay 2. Credits=4, same → stays 4, credit_overflow=0.
- Overflow: credits=4, transmit_credit pulse with write_valid=0 → credits stay 4, credit_overflow=1 and remains 1 through later traffic until reset.
- Reset mid-burst: assert reset while transmit_valid=1 and credits=1 → transmit_valid=0 without a clock edge, credits_available=4 after release, first post-reset transfer appears one cycle later.

Source files
------------

// File: rtl/credit_based_transmitter.sv
// Sending end of a credit-based link: forwards producer words one per credit
// and tracks the remote receiver's free slots with a saturating credit counter.
module credit_based_transmitter #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CREDIT_COUNT = 4,
  localparam int unsigned CREDIT_WIDTH = $clog2(CREDIT_COUNT + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        write_data,
  input  logic                    write_valid,
  output logic                    write_ready,
  output logic [WIDTH-1:0]        transmit_data,
  output logic                    transmit_valid,
  input  logic                    transmit_credit,
  output logic [CREDIT_WIDTH-1:0] credits_available,
  output logic                    credit_overflow,
  output logic                    idle
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(CREDIT_COUNT);

  logic [CREDIT_WIDTH-1:0] r_credits;
  logic [WIDTH-1:0]        r_tx_data;
  logic                    r_tx_valid;
  logic                    r_overflow;
  logic                    w_transfer;

  // Ready depends only on the registered counter, never on the credit input.
  assign write_ready = (r_credits != '0);
  assign w_transfer  = write_valid & write_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_credits  <= CREDIT_MAX;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_tx_valid <= w_transfer;
      if (w_transfer) r_tx_data <= write_data;
      // A consume and a return in the same cycle cancel, even when full.
      case ({w_transfer, transmit_credit})
        2'b10: r_credits <= r_credits - CREDIT_WIDTH'(1);
        2'b01: begin
          if (r_credits == CREDIT_MAX) r_overflow <= 1'b1;
          else                         r_credits  <= r_credits + CREDIT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign transmit_data     = r_tx_data;
  assign transmit_valid    = r_tx_valid;
  assign credits_available = r_credits;
  assign credit_overflow   = r_overflow;
  assign idle              = (r_credits == CREDIT_MAX) & ~r_tx_valid;

endmodule

// File: tb/tb_credit_based_transmitter.sv
// Directed bench for credit_based_transmitter: a scoreboard queue holds the
// expected link words and their arrival cycle; a negedge monitor checks them.
module tb_credit_based_transmitter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CC    = 4;
  localparam int unsigned CW    = $clog2(CC + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] write_data;
  logic             write_valid;
  logic             write_ready;
  logic [WIDTH-1:0] transmit_data;
  logic             transmit_valid;
  logic             transmit_credit;
  logic [CW-1:0]    credits_available;
  logic             credit_overflow;
  logic             idle;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               at;
  } exp_t;
  exp_t exp_q[$];

  credit_based_transmitter #(.WIDTH(WIDTH), .CREDIT_COUNT(CC)) dut (
    .clock             (clock),
    .reset             (reset),
    .write_data        (write_data),
    .write_valid       (write_valid),
    .write_ready       (write_ready),
    .transmit_data     (transmit_data),
    .transmit_valid    (transmit_valid),
    .transmit_credit   (transmit_credit),
    .credits_available (credits_available),
    .credit_overflow   (credit_overflow),
    .idle              (idle)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then stop at the falling edge.
  task automatic drive(input logic wv, input logic [WIDTH-1:0] d, input logic tc);
    @(posedge clock);
    #1;
    write_valid     = wv;
    write_data      = d;
    transmit_credit = tc;
    @(negedge clock);
  endtask

  // Word offered now is expected on the link one cycle later.
  task automatic expect_word(input logic [WIDTH-1:0] d);
    exp_t e;
    e.data = d;
    e.at   = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Monitor: every transmit_valid pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && transmit_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(transmit_data), 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("tx_data", 32'(transmit_data), 32'(e.data));
        chk("tx_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] burst [5];
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44; burst[4] = 8'h55;

    reset = 1'b1; write_valid = 1'b1; write_data = 8'hFF; transmit_credit = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_tv", 32'(transmit_valid), 32'd0);
    chk("rst_td", 32'(transmit_data), 32'd0);
    chk("rst_cred", 32'(credits_available), 32'd4);
    chk("rst_ready", 32'(write_ready), 32'd1);
    chk("rst_ovf", 32'(credit_overflow), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    write_valid = 1'b0; transmit_credit = 1'b0; write_data = '0;
    #2 reset = 1'b0;

    // Burst with no returns: four words go, the fifth is held off.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, burst[i], 1'b0);
      chk("burst_ready", 32'(write_ready), 32'd1);
      expect_word(burst[i]);
    end
    drive(1'b1, burst[4], 1'b0);
    chk("burst_stall", 32'(write_ready), 32'd0);
    chk("burst_cred0", 32'(credits_available), 32'd0);
    chk("burst_idle", 32'(idle), 32'd0);
    drive(1'b1, burst[4], 1'b0);
    chk("hold_ready", 32'(write_ready), 32'd0);
    drive(1'b1, burst[4], 1'b1);
    chk("ret_ready", 32'(write_ready), 32'd0);
    drive(1'b1, burst[4], 1'b0);
    chk("refill_ready", 32'(write_ready), 32'd1);
    chk("refill_cred", 32'(credits_available), 32'd1);
    expect_word(burst[4]);
    drive(1'b0, '0, 1'b0);
    chk("after55_cred", 32'(credits_available), 32'd0);
    chk("after55_ready", 32'(write_ready), 32'd0);

    // Simultaneous consume and return at credits=2.
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b1, 8'hA1, 1'b1);
    chk("sim2_before", 32'(credits_available), 32'd2);
    expect_word(8'hA1);
    drive(1'b0, '0, 1'b1);
    chk("sim2_after", 32'(credits_available), 32'd2);
    drive(1'b0, '0, 1'b1);
    chk("cred3", 32'(credits_available), 32'd3);

    // Simultaneous consume and return at full: no overflow.
    drive(1'b1, 8'hB2, 1'b1);
    chk("sim4_before", 32'(credits_available), 32'd4);
    chk("full_idle", 32'(idle), 32'd1);
    expect_word(8'hB2);
    drive(1'b0, '0, 1'b0);
    chk("sim4_after", 32'(credits_available), 32'd4);
    chk("sim4_ovf", 32'(credit_overflow), 32'd0);
    chk("busy_idle", 32'(idle), 32'd0);

    // Return at full: saturate and raise sticky overflow.
    drive(1'b0, '0, 1'b1);
    chk("idle_again", 32'(idle), 32'd1);
    drive(1'b1, 8'hC3, 1'b0);
    chk("ovf_cred", 32'(credits_available), 32'd4);
    chk("ovf_set", 32'(credit_overflow), 32'd1);
    expect_word(8'hC3);
    drive(1'b1, 8'hC4, 1'b0);
    expect_word(8'hC4);
    drive(1'b0, '0, 1'b1);
    chk("ovf_traffic_cred", 32'(credits_available), 32'd2);
    chk("ovf_sticky1", 32'(credit_overflow), 32'd1);
    drive(1'b0, '0, 1'b1);
    drive(1'b1, 8'hD1, 1'b0);
    chk("ovf_refill_cred", 32'(credits_available), 32'd4);
    chk("ovf_sticky2", 32'(credit_overflow), 32'd1);
    expect_word(8'hD1);
    drive(1'b1, 8'hD2, 1'b0);
    expect_word(8'hD2);
    drive(1'b1, 8'hD3, 1'b0);
    expect_word(8'hD3);
    drive(1'b0, '0, 1'b0);
    chk("pre_rst_cred", 32'(credits_available), 32'd1);
    chk("pre_rst_tv", 32'(transmit_valid), 32'd1);

    // Reset mid-operation: valid drops without a clock edge.
    #2 reset = 1'b1;
    #1;
    chk("midrst_tv", 32'(transmit_valid), 32'd0);
    chk("midrst_cred", 32'(credits_available), 32'd4);
    chk("midrst_ovf", 32'(credit_overflow), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    write_valid = 1'b1;
    write_data = 8'hE5;
    expect_word(8'hE5);
    @(negedge clock);
    chk("post_rst_ready", 32'(write_ready), 32'd1);
    drive(1'b0, '0, 1'b0);
    chk("post_rst_cred", 32'(credits_available), 32'd3);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
